btn_led_ctrl: RTL and testbench
===============================

BTN_LED_CTRL -- requirements
Module: btn_led_ctrl

Interface
REQ-001 Parameter NUM_LED, default 4: LED count and up/down counter width; legal range 2..16.
REQ-002 Parameter DEBOUNCE_CNT, default 16: consecutive stable samples needed to accept a button change; legal range 2..65535.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port btn_0, input, 1: asynchronous raw button, increment request.
REQ-006 Port btn_1, input, 1: asynchronous raw button, decrement request.
REQ-007 Port mode, input, 2: display mode select, sampled every cycle.
REQ-008 Port led, output, NUM_LED: registered LED drive.
REQ-009 Port btn_0_db and btn_1_db, output, 1 each: debounced button levels.
REQ-010 Port cnt, output, NUM_LED: current counter value.

Function
REQ-011 Each button SHALL pass through a 2-flop synchroniser, then a debouncer.
- Debouncer holds a stable level and a run counter.
- Run counter increments while the synchronised input differs from the stable level.
- Run counter clears whenever the input equals the stable level.
- Stable level flips, and the run counter clears, when the run counter reaches DEBOUNCE_CNT-1 with the input still differing.
REQ-012 A clean raw transition SHALL appear on btn_x_db exactly DEBOUNCE_CNT+2 clk edges later; a glitch shorter than DEBOUNCE_CNT cycles SHALL never reach btn_x_db.
REQ-013 Rising-edge detect SHALL run on each debounced level and produce a one-cycle pulse inc_p (btn_0) or dec_p (btn_1) on the cycle after btn_x_db rises.
REQ-014 cnt SHALL update on the edge that samples the pulse:
- inc_p alone: cnt+1, wrapping modulo 2^NUM_LED (all-ones -> 0).
- dec_p alone: cnt-1, wrapping (0 -> all-ones).
- inc_p and dec_p in the same cycle: cnt unchanged.
REQ-015 led SHALL be registered one cycle after cnt/mode, as follows:
- mode 00: cnt in binary.
- mode 01: one-hot, bit (cnt mod NUM_LED) set.
- mode 10: thermometer; the low min(cnt, NUM_LED) bits set.
- mode 11: led[0]=btn_0_db, led[1]=btn_1_db, other bits 0.
REQ-016 A mode change SHALL take effect on led one cycle later and SHALL NOT alter cnt.
REQ-017 Releasing a button SHALL produce no pulse and SHALL NOT change cnt.

Reset
REQ-018 While rst_n=0 at a clk edge, all of the following SHALL be 0:
- synchroniser flops, debounce stable levels and run counters, edge-detect history, cnt;
- outputs btn_0_db, btn_1_db, led.
REQ-019 Reset asserted mid-debounce or mid-press SHALL discard the partial run.
REQ-020 A button held through reset release SHALL be re-debounced and SHALL produce exactly one increment/decrement pulse.

Structure
REQ-021 Package btn_led_pkg SHALL hold:
- mode encodings MODE_BIN=2'b00, MODE_ONEHOT=2'b01, MODE_THERM=2'b10, MODE_RAW=2'b11;
- a function computing the run-counter width from DEBOUNCE_CNT.
REQ-022 The synchroniser plus debouncer SHALL be one sub-module, btn_debounce (parameter DEBOUNCE_CNT), instantiated twice.
REQ-023 The counter, edge detect and LED mux SHALL live in btn_led_ctrl.

Verification (bench: NUM_LED=4, DEBOUNCE_CNT=4)
REQ-024 Reset then mode=00; hold btn_0 high 20 cycles, then release -> btn_0_db rises 6 edges after btn_0; cnt=1 one edge later; led=4'b0001 one edge after that; no further change.
REQ-025 Pulse btn_0 high for 3 cycles, 10 times -> cnt stays 0; btn_0_db never rises.
REQ-026 17 clean btn_0 presses -> cnt goes 15 -> 0 -> 1; then one btn_1 press at cnt=0 -> cnt=15.
REQ-027 btn_0 and btn_1 rise on the same cycle at cnt=5 -> cnt stays 5; inc_p and dec_p pulse in the same cycle.
REQ-028 cnt=6 -> led as mode is swept:
- mode 01 -> led=4'b0100;
- mode 10 -> led=4'b1111;
- mode 11 with btn_1 held -> led=4'b0010.
REQ-029 Assert rst_n=0 2 cycles into a debounce run while btn_0 is held -> all outputs 0; after release of reset, exactly one increment -> cnt=1.

Source files
------------

// File: rtl/btn_led_pkg.sv
// Shared constants and helpers for the button/LED counter block.
package btn_led_pkg;

  localparam logic [1:0] MODE_BIN    = 2'b00;
  localparam logic [1:0] MODE_ONEHOT = 2'b01;
  localparam logic [1:0] MODE_THERM  = 2'b10;
  localparam logic [1:0] MODE_RAW    = 2'b11;

  // Smallest width that can hold DEBOUNCE_CNT-1 (never less than one bit).
  function automatic int run_cnt_w(input int debounce_cnt);
    int w;
    w = 1;
    while ((1 << w) < debounce_cnt) w++;
    return w;
  endfunction

endpackage

// File: rtl/btn_led_ctrl_debounce.sv
// Two-flop synchroniser followed by a run-length debouncer for one raw button.
module btn_debounce
  import btn_led_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic db_o
);

  localparam int              RW      = run_cnt_w(DEBOUNCE_CNT);
  localparam logic [RW-1:0]   RUN_MAX = RW'(DEBOUNCE_CNT - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [RW-1:0] run_q, run_d;

  // Any sample matching the stable level restarts the run from zero.
  always_comb begin
    stable_d = stable_q;
    run_d    = '0;
    if (sync2_q != stable_q) begin
      if (run_q == RUN_MAX) begin
        stable_d = sync2_q;
      end else begin
        run_d = run_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      run_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      run_q    <= run_d;
    end
  end

  assign db_o = stable_q;

endmodule

// File: rtl/btn_led_ctrl.sv
// Debounced two-button up/down counter with a selectable LED display pattern.
module btn_led_ctrl
  import btn_led_pkg::*;
#(
  parameter int NUM_LED      = 4,
  parameter int DEBOUNCE_CNT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_0,
  input  logic               btn_1,
  input  logic [1:0]         mode,
  output logic [NUM_LED-1:0] led,
  output logic               btn_0_db,
  output logic               btn_1_db,
  output logic [NUM_LED-1:0] cnt
);

  logic               prev0_q, prev1_q;
  logic               inc_p, dec_p;
  logic [NUM_LED-1:0] cnt_q, cnt_d;
  logic [NUM_LED-1:0] led_q, led_d;
  logic [NUM_LED-1:0] onehot, therm;

  btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db0 (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_i (btn_0),
    .db_o  (btn_0_db)
  );

  btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db1 (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_i (btn_1),
    .db_o  (btn_1_db)
  );

  // Only rising edges count, so releases never move the counter.
  assign inc_p = btn_0_db & ~prev0_q;
  assign dec_p = btn_1_db & ~prev1_q;

  always_comb begin
    case ({inc_p, dec_p})
      2'b10:   cnt_d = cnt_q + NUM_LED'(1);
      2'b01:   cnt_d = cnt_q - NUM_LED'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    onehot = '0;
    therm  = '0;
    for (int i = 0; i < NUM_LED; i++) begin
      onehot[i] = ((int'(cnt_q) % NUM_LED) == i);
      therm[i]  = (int'(cnt_q) > i);
    end
  end

  always_comb begin
    led_d = '0;
    case (mode)
      MODE_BIN:    led_d = cnt_q;
      MODE_ONEHOT: led_d = onehot;
      MODE_THERM:  led_d = therm;
      default: begin
        led_d[0] = btn_0_db;
        led_d[1] = btn_1_db;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev0_q <= 1'b0;
      prev1_q <= 1'b0;
      cnt_q   <= '0;
      led_q   <= '0;
    end else begin
      prev0_q <= btn_0_db;
      prev1_q <= btn_1_db;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
    end
  end

  assign cnt = cnt_q;
  assign led = led_q;

endmodule

// File: tb/tb_btn_led_ctrl.sv
// Directed bench for btn_led_ctrl with NUM_LED=4, DEBOUNCE_CNT=4.
module tb_btn_led_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn_0, btn_1;
  logic [1:0] mode;
  logic [3:0] led, cnt;
  logic       btn_0_db, btn_1_db;

  int total;
  int bad;

  typedef struct {
    logic       b0;
    logic       b1;
    logic [1:0] mode;
    logic [3:0] exp_cnt;
    logic [3:0] exp_led;
  } vec_t;

  vec_t tbl[$];

  btn_led_ctrl #(.NUM_LED(4), .DEBOUNCE_CNT(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_0    (btn_0),
    .btn_1    (btn_1),
    .mode     (mode),
    .led      (led),
    .btn_0_db (btn_0_db),
    .btn_1_db (btn_1_db),
    .cnt      (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic b0, input logic b1, input logic [1:0] m,
                     input logic [3:0] c, input logic [3:0] l);
    vec_t v;
    v.b0 = b0; v.b1 = b1; v.mode = m; v.exp_cnt = c; v.exp_led = l;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic press(input logic b0, input logic b1);
    btn_0 = b0;
    btn_1 = b1;
    tick(10);
    btn_0 = 1'b0;
    btn_1 = 1'b0;
    tick(12);
  endtask

  initial begin
    int t;
    int rose;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    btn_0 = 1'b0;
    btn_1 = 1'b0;
    mode  = 2'b00;

    add(1,0,2'b10, 4'd1,  4'b0001);
    add(1,0,2'b10, 4'd2,  4'b0011);
    add(1,0,2'b10, 4'd3,  4'b0111);
    add(1,0,2'b01, 4'd4,  4'b0001);
    add(1,0,2'b01, 4'd5,  4'b0010);
    add(1,0,2'b01, 4'd6,  4'b0100);
    add(1,0,2'b01, 4'd7,  4'b1000);
    add(1,0,2'b00, 4'd8,  4'b1000);
    add(1,0,2'b10, 4'd9,  4'b1111);
    add(1,0,2'b00, 4'd10, 4'b1010);
    add(1,0,2'b00, 4'd11, 4'b1011);
    add(1,0,2'b00, 4'd12, 4'b1100);
    add(1,0,2'b00, 4'd13, 4'b1101);
    add(1,0,2'b00, 4'd14, 4'b1110);
    add(1,0,2'b00, 4'd15, 4'b1111);
    add(1,0,2'b00, 4'd0,  4'b0000);
    add(1,0,2'b00, 4'd1,  4'b0001);
    add(0,1,2'b00, 4'd0,  4'b0000);
    add(0,1,2'b00, 4'd15, 4'b1111);
    add(0,1,2'b01, 4'd14, 4'b0100);
    add(0,1,2'b01, 4'd13, 4'b0010);
    add(0,1,2'b00, 4'd12, 4'b1100);
    add(0,1,2'b00, 4'd11, 4'b1011);
    add(0,1,2'b00, 4'd10, 4'b1010);
    add(0,1,2'b00, 4'd9,  4'b1001);
    add(0,1,2'b00, 4'd8,  4'b1000);
    add(0,1,2'b00, 4'd7,  4'b0111);
    add(0,1,2'b00, 4'd6,  4'b0110);
    add(0,0,2'b01, 4'd6,  4'b0100);
    add(0,0,2'b10, 4'd6,  4'b1111);
    add(0,0,2'b00, 4'd6,  4'b0110);
    add(0,1,2'b10, 4'd5,  4'b1111);
    add(0,0,2'b01, 4'd5,  4'b0010);

    // Reset state
    tick(3);
    chk("rst_cnt", 16'(cnt), 16'h0);
    chk("rst_led", 16'(led), 16'h0);
    chk("rst_db0", 16'(btn_0_db), 16'h0);
    chk("rst_db1", 16'(btn_1_db), 16'h0);
    rst_n = 1'b1;
    tick(2);

    // Single long press: latency and one increment
    btn_0 = 1'b1;
    t = 0;
    while (btn_0_db == 1'b0 && t < 30) begin
      tick(1);
      t++;
    end
    chk("db_latency", 16'(t), 16'd6);
    chk("cnt_before_pulse", 16'(cnt), 16'd0);
    tick(1);
    chk("cnt_after_pulse", 16'(cnt), 16'd1);
    chk("led_lag", 16'(led), 16'd0);
    tick(1);
    chk("led_bin", 16'(led), 16'b0001);
    tick(12);
    btn_0 = 1'b0;
    tick(20);
    chk("cnt_after_release", 16'(cnt), 16'd1);
    chk("led_after_release", 16'(led), 16'b0001);
    chk("db0_after_release", 16'(btn_0_db), 16'd0);

    // Glitches of DEBOUNCE_CNT-1 cycles never pass
    do_reset();
    rose = 0;
    for (int g = 0; g < 10; g++) begin
      btn_0 = 1'b1;
      for (int k = 0; k < 3; k++) begin tick(1); if (btn_0_db) rose++; end
      btn_0 = 1'b0;
      for (int k = 0; k < 3; k++) begin tick(1); if (btn_0_db) rose++; end
    end
    tick(10);
    chk("glitch_db", 16'(rose), 16'd0);
    chk("glitch_cnt", 16'(cnt), 16'd0);

    // Table of presses and mode changes
    foreach (tbl[i]) begin
      mode = tbl[i].mode;
      if (tbl[i].b0 || tbl[i].b1) press(tbl[i].b0, tbl[i].b1);
      else tick(3);
      chk($sformatf("tbl%0d_cnt", i), 16'(cnt), 16'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d_led", i), 16'(led), 16'(tbl[i].exp_led));
    end

    // Raw mode shows the debounced btn_1 level
    mode  = 2'b11;
    btn_1 = 1'b1;
    tick(9);
    chk("raw_led_held", 16'(led), 16'b0010);
    chk("raw_cnt_dec", 16'(cnt), 16'd4);
    btn_1 = 1'b0;
    tick(12);
    chk("raw_led_rel", 16'(led), 16'b0000);
    mode = 2'b00;
    press(1'b1, 1'b0);
    chk("cnt_back_to_5", 16'(cnt), 16'd5);

    // Simultaneous inc and dec cancel
    btn_0 = 1'b1;
    btn_1 = 1'b1;
    t = 0;
    while (btn_0_db == 1'b0 && btn_1_db == 1'b0 && t < 30) begin
      tick(1);
      t++;
    end
    chk("both_latency", 16'(t), 16'd6);
    chk("both_db_same", 16'({btn_0_db, btn_1_db}), 16'b11);
    tick(5);
    chk("both_cnt_held", 16'(cnt), 16'd5);
    btn_0 = 1'b0;
    btn_1 = 1'b0;
    tick(12);
    chk("both_cnt_rel", 16'(cnt), 16'd5);
    chk("both_led", 16'(led), 16'd5);

    // Reset in the middle of a debounce run with the button held
    btn_0 = 1'b1;
    tick(4);
    rst_n = 1'b0;
    tick(2);
    chk("midrst_cnt", 16'(cnt), 16'd0);
    chk("midrst_led", 16'(led), 16'd0);
    chk("midrst_db", 16'({btn_0_db, btn_1_db}), 16'd0);
    rst_n = 1'b1;
    tick(30);
    chk("midrst_cnt_one", 16'(cnt), 16'd1);
    chk("midrst_db0_high", 16'(btn_0_db), 16'd1);
    btn_0 = 1'b0;
    tick(15);
    chk("midrst_cnt_final", 16'(cnt), 16'd1);
    chk("midrst_led_final", 16'(led), 16'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
